// File: rtl/mux_scan_controller.sv
// mux_scan_controller: drives the EIT electrode multiplexers over a mode-0 SPI
// link. Each frame is {src, snk}, sent MSB first. In direct mode the frame is
// mux_val. In scan mode a pointer steps the drive pair around the ring. The
// last completed frame is mirrored on gpio_mux. All outputs are registered.
module mux_scan_controller #(
    parameter int N_ELEC   = 16,
    parameter int IDX_W    = 4,
    parameter int SKIP     = 0,
    parameter int SCLK_DIV = 2,
    parameter int CS_SETUP = 1,
    parameter int CS_HOLD  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_mux,
    input  logic                 mode,
    input  logic [2*IDX_W-1:0]   mux_val,
    input  logic                 scan_clr,
    output logic                 busy,
    output logic                 mux_done,
    output logic                 scan_wrap,
    output logic                 spi_clk,
    output logic                 spi_mosi,
    output logic                 spi_cs,
    output logic [2*IDX_W-1:0]   gpio_mux
);

    localparam int DATA_W = 2 * IDX_W;
    localparam int BIT_W  = $clog2(DATA_W);
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                ph_q, ph_d;        // 0: SCLK low half, 1: SCLK high half
    logic [DATA_W-1:0]   frame_q, frame_d;
    logic                mode_q, mode_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic                start_q;

    logic                cs_q, cs_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wrap_q, wrap_d;
    logic [DATA_W-1:0]   gpio_q, gpio_d;

    logic                accept;
    logic [IDX_W-1:0]    ptr_eff;
    logic [IDX_W:0]      snk_sum;

    // Next-state logic and registered-output precompute for the frame FSM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        ph_d     = ph_q;
        frame_d  = frame_q;
        mode_d   = mode_q;
        gpio_d   = gpio_q;
        wrap_d   = 1'b0;

        accept   = start_mux && !start_q && (state_q == S_IDLE);
        // A clear in IDLE takes effect before a same-cycle scan frame is built
        ptr_eff  = (state_q == S_IDLE && scan_clr) ? '0 : ptr_q;
        ptr_d    = ptr_eff;

        snk_sum  = {1'b0, ptr_eff} + (IDX_W+1)'(1 + SKIP);
        if (snk_sum >= (IDX_W+1)'(N_ELEC)) begin
            snk_sum = snk_sum - (IDX_W+1)'(N_ELEC);
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SETUP;
                    cnt_d   = CNT_W'(CS_SETUP - 1);
                    mode_d  = mode;
                    frame_d = mode ? {ptr_eff, snk_sum[IDX_W-1:0]} : mux_val;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_SHIFT;
                    cnt_d   = CNT_W'(SCLK_DIV - 1);
                    ph_d    = 1'b0;
                    bit_d   = BIT_W'(DATA_W - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!ph_q) begin
                    ph_d  = 1'b1;
                    cnt_d = CNT_W'(SCLK_DIV - 1);
                end else if (bit_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = CNT_W'(CS_HOLD - 1);
                    ph_d    = 1'b0;
                end else begin
                    bit_d = bit_q - 1'b1;
                    ph_d  = 1'b0;
                    cnt_d = CNT_W'(SCLK_DIV - 1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    gpio_d  = frame_q;
                    if (mode_q) begin
                        wrap_d = (ptr_q == IDX_W'(N_ELEC - 1));
                        ptr_d  = (ptr_q == IDX_W'(N_ELEC - 1)) ? '0 : ptr_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cs_d   = !(state_d == S_SETUP || state_d == S_SHIFT || state_d == S_HOLD);
        sclk_d = (state_d == S_SHIFT) && ph_d;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        case (state_d)
            S_SETUP: mosi_d = frame_d[DATA_W-1];
            S_SHIFT: mosi_d = frame_d[bit_d];
            default: mosi_d = 1'b0;
        endcase
    end

    // State, datapath and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            ph_q    <= 1'b0;
            frame_q <= '0;
            mode_q  <= 1'b0;
            ptr_q   <= '0;
            start_q <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            gpio_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            ph_q    <= ph_d;
            frame_q <= frame_d;
            mode_q  <= mode_d;
            ptr_q   <= ptr_d;
            start_q <= start_mux;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            gpio_q  <= gpio_d;
        end
    end

    assign spi_cs    = cs_q;
    assign spi_clk   = sclk_q;
    assign spi_mosi  = mosi_q;
    assign busy      = busy_q;
    assign mux_done  = done_q;
    assign scan_wrap = wrap_q;
    assign gpio_mux  = gpio_q;

endmodule
